mult_issue_queue: RTL and testbench

- In-order issue queue for the multiply functional unit; sits between the dispatch stage and the multiply execution unit.
- Buffers dispatched multiply ops and snoops the CDB to wake up pending source operands.
- Raises an issue request when the head entry has both operands ready.
- On grant from the issue arbiter, presents the head operands and destination tag as the common_fifo_data fields (rs1_data, rs2_data, rd_tag) consumed by the mult execution unit, then pops the head.

---
 rtl/mult_issue_queue.sv | 161 ++++++++++++++++
 tb/tb_mult_issue_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_queue.sv
// mult_issue_queue: in-order issue queue feeding the multiply execution unit.
// Buffers dispatched multiply ops, snoops the CDB to wake pending sources and
// requests issue when the head entry has both operands ready. On grant the
// head fields (rs1_data, rs2_data, rd_tag) are consumed in the same cycle and
// the head is popped at the edge.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   i_flush                  synchronous clear of the whole queue
//   i_dispatch_en, i_rd_tag,
//   i_rsX_data/tag/rdy       new entry from dispatch (dropped when full)
//   i_cdb_valid/tag/result   CDB broadcast used for wakeup
//   i_issue_granted          arbiter grant, pops the head when o_issue_req
//   o_issue_req              head valid with both operands ready
//   o_rs1_data, o_rs2_data,
//   o_rd_tag                 head contents, zero when empty
//   o_full, o_empty          occupancy flags from the count register
module mult_issue_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_dispatch_en,
  input  logic [TAG_W-1:0]  i_rd_tag,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [TAG_W-1:0]  i_rs1_tag,
  input  logic              i_rs1_rdy,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic [TAG_W-1:0]  i_rs2_tag,
  input  logic              i_rs2_rdy,
  input  logic              i_cdb_valid,
  input  logic [TAG_W-1:0]  i_cdb_tag,
  input  logic [DATA_W-1:0] i_cdb_result,
  input  logic              i_issue_granted,
  output logic              o_issue_req,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rs1_data;
    logic [TAG_W-1:0]  rs1_tag;
    logic              rs1_rdy;
    logic [DATA_W-1:0] rs2_data;
    logic [TAG_W-1:0]  rs2_tag;
    logic              rs2_rdy;
  } entry_t;

  entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  entry_t head;
  entry_t new_entry;
  logic   push;
  logic   pop;
  logic   rs1_hit;
  logic   rs2_hit;

  // Head view and status, all derived from registered state
  assign head        = entries_q[rd_ptr_q];
  assign o_empty     = (count_q == '0);
  assign o_full      = (count_q == CNT_W'(DEPTH));
  assign o_issue_req = !o_empty && head.rs1_rdy && head.rs2_rdy;
  assign o_rs1_data  = o_empty ? '0 : head.rs1_data;
  assign o_rs2_data  = o_empty ? '0 : head.rs2_data;
  assign o_rd_tag    = o_empty ? '0 : head.rd_tag;

  assign push = i_dispatch_en && !o_full;
  assign pop  = i_issue_granted && o_issue_req;

  // Dispatch bypass: a source whose producer broadcasts this very cycle is
  // written already-ready, otherwise it would miss its only wakeup.
  assign rs1_hit = !i_rs1_rdy && i_cdb_valid && (i_cdb_tag == i_rs1_tag);
  assign rs2_hit = !i_rs2_rdy && i_cdb_valid && (i_cdb_tag == i_rs2_tag);

  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.rd_tag   = i_rd_tag;
    new_entry.rs1_tag  = i_rs1_tag;
    new_entry.rs1_rdy  = i_rs1_rdy || rs1_hit;
    new_entry.rs1_data = rs1_hit ? i_cdb_result : i_rs1_data;
    new_entry.rs2_tag  = i_rs2_tag;
    new_entry.rs2_rdy  = i_rs2_rdy || rs2_hit;
    new_entry.rs2_data = rs2_hit ? i_cdb_result : i_rs2_data;
  end

  // Next-state: snoop, then pop, then push; flush overrides everything
  always_comb begin
    entries_d = entries_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_cdb_valid && entries_q[i].valid) begin
        if (!entries_q[i].rs1_rdy && (entries_q[i].rs1_tag == i_cdb_tag)) begin
          entries_d[i].rs1_rdy  = 1'b1;
          entries_d[i].rs1_data = i_cdb_result;
        end
        if (!entries_q[i].rs2_rdy && (entries_q[i].rs2_tag == i_cdb_tag)) begin
          entries_d[i].rs2_rdy  = 1'b1;
          entries_d[i].rs2_data = i_cdb_result;
        end
      end
    end

    if (pop) begin
      entries_d[rd_ptr_q] = '0;
      rd_ptr_d            = rd_ptr_q + PTR_W'(1);
    end

    // Push never aliases the popped slot: push implies not full, and pop
    // implies not empty, so wr_ptr differs from rd_ptr whenever both fire.
    if (push) begin
      entries_d[wr_ptr_q] = new_entry;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (i_flush) begin
      entries_d = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_mult_issue_queue.sv
// Directed bench for mult_issue_queue (DEPTH=4, DATA_W=32, TAG_W=6).
module tb_mult_issue_queue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 6;

  logic              clk;
  logic              rst;
  logic              i_flush;
  logic              i_dispatch_en;
  logic [TAG_W-1:0]  i_rd_tag;
  logic [DATA_W-1:0] i_rs1_data;
  logic [TAG_W-1:0]  i_rs1_tag;
  logic              i_rs1_rdy;
  logic [DATA_W-1:0] i_rs2_data;
  logic [TAG_W-1:0]  i_rs2_tag;
  logic              i_rs2_rdy;
  logic              i_cdb_valid;
  logic [TAG_W-1:0]  i_cdb_tag;
  logic [DATA_W-1:0] i_cdb_result;
  logic              i_issue_granted;
  logic              o_issue_req;
  logic [DATA_W-1:0] o_rs1_data;
  logic [DATA_W-1:0] o_rs2_data;
  logic [TAG_W-1:0]  o_rd_tag;
  logic              o_full;
  logic              o_empty;

  int checks = 0;
  int errors = 0;

  mult_issue_queue #(.DEPTH(4), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_flush         (i_flush),
    .i_dispatch_en   (i_dispatch_en),
    .i_rd_tag        (i_rd_tag),
    .i_rs1_data      (i_rs1_data),
    .i_rs1_tag       (i_rs1_tag),
    .i_rs1_rdy       (i_rs1_rdy),
    .i_rs2_data      (i_rs2_data),
    .i_rs2_tag       (i_rs2_tag),
    .i_rs2_rdy       (i_rs2_rdy),
    .i_cdb_valid     (i_cdb_valid),
    .i_cdb_tag       (i_cdb_tag),
    .i_cdb_result    (i_cdb_result),
    .i_issue_granted (i_issue_granted),
    .o_issue_req     (o_issue_req),
    .o_rs1_data      (o_rs1_data),
    .o_rs2_data      (o_rs2_data),
    .o_rd_tag        (o_rd_tag),
    .o_full          (o_full),
    .o_empty         (o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_flush = 0; i_dispatch_en = 0; i_issue_granted = 0; i_cdb_valid = 0;
    i_rd_tag = '0; i_rs1_data = '0; i_rs1_tag = '0; i_rs1_rdy = 0;
    i_rs2_data = '0; i_rs2_tag = '0; i_rs2_rdy = 0; i_cdb_tag = '0; i_cdb_result = '0;
  endtask

  task automatic disp(input logic [TAG_W-1:0] rd,
                      input logic [DATA_W-1:0] d1, input logic [TAG_W-1:0] t1, input logic r1,
                      input logic [DATA_W-1:0] d2, input logic [TAG_W-1:0] t2, input logic r2);
    i_dispatch_en = 1; i_rd_tag = rd;
    i_rs1_data = d1; i_rs1_tag = t1; i_rs1_rdy = r1;
    i_rs2_data = d2; i_rs2_tag = t2; i_rs2_rdy = r2;
  endtask

  task automatic disp_rdy(input logic [TAG_W-1:0] rd);
    disp(rd, 32'(rd), '0, 1'b1, 32'(rd) + 32'h100, '0, 1'b1);
  endtask

  // Grant the head once, after checking it carries the expected rd_tag
  task automatic pop_expect(input string tag, input logic [TAG_W-1:0] rd);
    check({tag, "_req"}, 64'(o_issue_req), 64'(1));
    check({tag, "_rd"}, 64'(o_rd_tag), 64'(rd));
    i_issue_granted = 1;
    tick();
    i_issue_granted = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    #2;
    check("rst_empty", 64'(o_empty), 64'(1));
    check("rst_full", 64'(o_full), 64'(0));
    check("rst_req", 64'(o_issue_req), 64'(0));
    check("rst_data", {o_rs1_data, o_rs2_data}, 64'(0));
    check("rst_rd", 64'(o_rd_tag), 64'(0));
    tick(); tick();
    rst = 0;
    tick();

    // Basic ready dispatch and issue
    disp(6'd5, 32'd3, '0, 1'b1, 32'd7, '0, 1'b1);
    tick(); idle();
    check("b_req", 64'(o_issue_req), 64'(1));
    check("b_rs1", 64'(o_rs1_data), 64'(3));
    check("b_rs2", 64'(o_rs2_data), 64'(7));
    check("b_rd", 64'(o_rd_tag), 64'(5));
    check("b_empty0", 64'(o_empty), 64'(0));
    i_issue_granted = 1;
    tick(); idle();
    check("b_empty1", 64'(o_empty), 64'(1));
    check("b_req0", 64'(o_issue_req), 64'(0));

    // CDB wakeup two cycles after dispatch
    disp(6'd10, 32'd1, '0, 1'b1, 32'hdead, 6'd9, 1'b0);
    tick(); idle();
    check("w_req_a", 64'(o_issue_req), 64'(0));
    tick();
    check("w_req_b", 64'(o_issue_req), 64'(0));
    i_cdb_valid = 1; i_cdb_tag = 6'd9; i_cdb_result = 32'h20;
    tick(); idle();
    check("w_req_c", 64'(o_issue_req), 64'(1));
    check("w_rs2", 64'(o_rs2_data), 64'h20);
    pop_expect("w_pop", 6'd10);

    // Broadcast coincident with dispatch
    disp(6'd11, 32'd2, '0, 1'b1, 32'hbeef, 6'd9, 1'b0);
    i_cdb_valid = 1; i_cdb_tag = 6'd9; i_cdb_result = 32'h21;
    tick(); idle();
    check("byp_rs2", 64'(o_rs2_data), 64'h21);
    pop_expect("byp_pop", 6'd11);
    check("byp_empty", 64'(o_empty), 64'(1));

    // Fill, drop on full, drain in order, then wrap
    for (int k = 1; k <= 4; k++) begin
      disp_rdy(6'(k));
      tick();
    end
    idle();
    check("f_full", 64'(o_full), 64'(1));
    disp_rdy(6'd63);
    tick(); idle();
    check("f_full_drop", 64'(o_full), 64'(1));
    check("f_rs2", 64'(o_rs2_data), 64'h101);
    for (int k = 1; k <= 4; k++) pop_expect("f_order", 6'(k));
    check("f_empty", 64'(o_empty), 64'(1));
    disp_rdy(6'd20); tick();
    disp_rdy(6'd21); tick(); idle();
    pop_expect("wrap", 6'd20);
    pop_expect("wrap", 6'd21);
    check("wrap_empty", 64'(o_empty), 64'(1));

    // Head pending blocks a ready younger entry
    disp(6'd30, 32'h0, 6'd12, 1'b0, 32'd4, '0, 1'b1); tick();
    disp_rdy(6'd31); tick(); idle();
    check("hol_req", 64'(o_issue_req), 64'(0));
    check("hol_rd", 64'(o_rd_tag), 64'd30);
    i_issue_granted = 1;
    tick(); idle();
    check("hol_ign_rd", 64'(o_rd_tag), 64'd30);
    i_cdb_valid = 1; i_cdb_tag = 6'd12; i_cdb_result = 32'h55;
    tick(); idle();
    check("hol_rs1", 64'(o_rs1_data), 64'h55);
    pop_expect("hol_pop", 6'd30);
    pop_expect("hol_pop", 6'd31);
    check("hol_empty", 64'(o_empty), 64'(1));

    // Simultaneous push and pop at count 2
    disp_rdy(6'd40); tick();
    disp_rdy(6'd41); tick();
    disp_rdy(6'd42); i_issue_granted = 1;
    tick(); idle();
    pop_expect("pp2", 6'd41);
    pop_expect("pp2", 6'd42);
    check("pp2_empty", 64'(o_empty), 64'(1));

    // Simultaneous push and pop at full: push rejected
    for (int k = 50; k <= 53; k++) begin
      disp_rdy(6'(k));
      tick();
    end
    idle();
    check("ppf_full", 64'(o_full), 64'(1));
    disp_rdy(6'd54); i_issue_granted = 1;
    tick(); idle();
    check("ppf_full0", 64'(o_full), 64'(0));
    pop_expect("ppf", 6'd51);
    pop_expect("ppf", 6'd52);
    pop_expect("ppf", 6'd53);
    check("ppf_empty", 64'(o_empty), 64'(1));

    // Flush beats concurrent dispatch
    for (int k = 60; k <= 62; k++) begin
      disp_rdy(6'(k));
      tick();
    end
    disp_rdy(6'd63); i_flush = 1;
    tick(); idle();
    check("fl_empty", 64'(o_empty), 64'(1));
    check("fl_req", 64'(o_issue_req), 64'(0));
    disp_rdy(6'd7); tick(); idle();
    check("fl_after_rd", 64'(o_rd_tag), 64'd7);

    // Async reset between edges
    disp_rdy(6'd8); tick(); idle();
    #2 rst = 1;
    #1;
    check("ar_empty", 64'(o_empty), 64'(1));
    check("ar_req", 64'(o_issue_req), 64'(0));
    check("ar_data", {o_rs1_data, o_rs2_data}, 64'(0));
    check("ar_rd", 64'(o_rd_tag), 64'(0));
    #1 rst = 0;
    tick();
    check("ar_hold", 64'(o_empty), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
